// File: rtl/mem_write_checker.sv
// mem_write_checker: snoops the processor's data-memory write port and checks
// the writes against a loadable, ordered table of expected (address, data)
// pairs. It reports pass, fail on mismatch, or fail on timeout, and captures
// the write that caused a mismatch.
module mem_write_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int TIM_W  = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] data_adr,
    input  logic [WIDTH-1:0] write_data,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_adr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ignore_en,
    input  logic [WIDTH-1:0] ignore_adr,
    input  logic             strict,
    input  logic             start,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] loaded_cnt,
    output logic             load_full,
    output logic [CNT_W-1:0] match_cnt,
    output logic [TIM_W-1:0] cycle_cnt,
    output logic [WIDTH-1:0] fail_adr,
    output logic [WIDTH-1:0] fail_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } stateT;

    stateT state, nextState;

    logic [WIDTH-1:0] expAdr  [DEPTH];
    logic [WIDTH-1:0] expData [DEPTH];

    logic [WIDTH-1:0] entryAdr;
    logic [WIDTH-1:0] entryData;
    logic             ignoreHit;
    logic             entryHit;
    logic             matchDone;
    logic             mismatch;
    logic             timeoutHit;
    logic             tableEmpty;
    logic             tableFull;
    logic             doMismatch;
    logic             doTimeout;

    // Pick the table entry that the next write is expected to hit.
    always_comb begin
        entryAdr  = '0;
        entryData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match_cnt == CNT_W'(i)) begin
                entryAdr  = expAdr[i];
                entryData = expData[i];
            end
        end
    end

    // Classify the current write and work out which RUN event (if any) fires.
    always_comb begin
        tableEmpty = (loaded_cnt == '0);
        tableFull  = (loaded_cnt == CNT_W'(DEPTH));
        ignoreHit  = ignore_en && (data_adr == ignore_adr);
        entryHit   = mem_write && !ignoreHit && (match_cnt < loaded_cnt) &&
                     (data_adr == entryAdr) && (write_data == entryData);
        matchDone  = entryHit && ((match_cnt + CNT_W'(1)) == loaded_cnt);
        mismatch   = mem_write && !ignoreHit && !entryHit && strict;
        timeoutHit = (cycle_cnt == TIM_W'(TIMEOUT - 1));
        doMismatch = (state == RUN) && !clear && !tableEmpty && mismatch;
        doTimeout  = (state == RUN) && !clear && !tableEmpty && !matchDone &&
                     !mismatch && timeoutHit;
    end

    // Next-state logic; clear wins from any state, and PASS beats a timeout.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) nextState = RUN;
            end
            RUN: begin
                if (tableEmpty || matchDone) nextState = PASS;
                else if (mismatch)           nextState = FAIL;
                else if (timeoutHit)         nextState = FAIL;
            end
            PASS:    nextState = PASS;
            FAIL:    nextState = FAIL;
            default: nextState = IDLE;
        endcase
        if (clear) nextState = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Expected-write table: appended in IDLE, flushed by clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                expAdr[i]  <= '0;
                expData[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                expAdr[i]  <= '0;
                expData[i] <= '0;
            end
        end else if (state == IDLE && load_en && !tableFull) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (loaded_cnt == CNT_W'(i)) begin
                    expAdr[i]  <= load_adr;
                    expData[i] <= load_data;
                end
            end
        end
    end

    // Counters, sticky full flag and fail capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loaded_cnt <= '0;
            load_full  <= 1'b0;
            match_cnt  <= '0;
            cycle_cnt  <= '0;
            fail_code  <= 2'd0;
            fail_adr   <= '0;
            fail_data  <= '0;
        end else if (clear) begin
            loaded_cnt <= '0;
            load_full  <= 1'b0;
            match_cnt  <= '0;
            cycle_cnt  <= '0;
            fail_code  <= 2'd0;
            fail_adr   <= '0;
            fail_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_en) begin
                        if (tableFull) load_full  <= 1'b1;
                        else           loaded_cnt <= loaded_cnt + CNT_W'(1);
                    end
                    if (start) begin
                        match_cnt <= '0;
                        cycle_cnt <= '0;
                    end
                end
                RUN: begin
                    if (cycle_cnt != TIM_W'(TIMEOUT))
                        cycle_cnt <= cycle_cnt + TIM_W'(1);
                    if (entryHit)
                        match_cnt <= match_cnt + CNT_W'(1);
                    if (doMismatch) begin
                        fail_code <= 2'd1;
                        fail_adr  <= data_adr;
                        fail_data <= write_data;
                    end else if (doTimeout) begin
                        fail_code <= 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags decode straight from the state register.
    always_comb begin
        busy = (state == RUN);
        pass = (state == PASS);
        fail = (state == FAIL);
        done = (state == PASS) || (state == FAIL);
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed self-checking bench for mem_write_checker
// with DEPTH=4 and TIMEOUT=16.
module tb_mem_write_checker;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int TIM_W   = $clog2(TIMEOUT + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             mem_write = 1'b0;
    logic [WIDTH-1:0] data_adr = '0;
    logic [WIDTH-1:0] write_data = '0;
    logic             load_en = 1'b0;
    logic [WIDTH-1:0] load_adr = '0;
    logic [WIDTH-1:0] load_data = '0;
    logic             ignore_en = 1'b0;
    logic [WIDTH-1:0] ignore_adr = '0;
    logic             strict = 1'b0;
    logic             start = 1'b0;
    logic             clear = 1'b0;
    logic             busy, done, pass, fail, load_full;
    logic [1:0]       fail_code;
    logic [CNT_W-1:0] loaded_cnt, match_cnt;
    logic [TIM_W-1:0] cycle_cnt;
    logic [WIDTH-1:0] fail_adr, fail_data;

    int errors = 0;
    int checks = 0;

    mem_write_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data), .load_en(load_en), .load_adr(load_adr),
        .load_data(load_data), .ignore_en(ignore_en), .ignore_adr(ignore_adr),
        .strict(strict), .start(start), .clear(clear), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .fail_code(fail_code), .loaded_cnt(loaded_cnt),
        .load_full(load_full), .match_cnt(match_cnt), .cycle_cnt(cycle_cnt),
        .fail_adr(fail_adr), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] adr, input logic [WIDTH-1:0] dat);
        mem_write = 1'b1; data_adr = adr; write_data = dat;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic doLoad(input logic [WIDTH-1:0] adr, input logic [WIDTH-1:0] dat);
        load_en = 1'b1; load_adr = adr; load_data = dat;
        tick();
        load_en = 1'b0;
    endtask

    task automatic doStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic doClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".busy"},       32'(busy),       0);
        checkOutput({tag, ".done"},       32'(done),       0);
        checkOutput({tag, ".pass"},       32'(pass),       0);
        checkOutput({tag, ".fail"},       32'(fail),       0);
        checkOutput({tag, ".fail_code"},  32'(fail_code),  0);
        checkOutput({tag, ".loaded_cnt"}, 32'(loaded_cnt), 0);
        checkOutput({tag, ".load_full"},  32'(load_full),  0);
        checkOutput({tag, ".match_cnt"},  32'(match_cnt),  0);
        checkOutput({tag, ".cycle_cnt"},  32'(cycle_cnt),  0);
        checkOutput({tag, ".fail_adr"},   fail_adr,        0);
        checkOutput({tag, ".fail_data"},  fail_data,       0);
    endtask

    initial begin
        // Reset state
        #12;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Ignored write then matching write -> PASS
        ignore_adr = 96; ignore_en = 1'b1; strict = 1'b1;
        doLoad(100, 7);
        checkOutput("t1.loaded_cnt", 32'(loaded_cnt), 1);
        doStart();
        checkOutput("t1.busy", 32'(busy), 1);
        checkOutput("t1.cycle_start", 32'(cycle_cnt), 0);
        applyStimulus(96, 3);
        checkOutput("t1.ignore_match", 32'(match_cnt), 0);
        checkOutput("t1.ignore_busy", 32'(busy), 1);
        applyStimulus(100, 7);
        checkOutput("t1.pass", 32'(pass), 1);
        checkOutput("t1.done", 32'(done), 1);
        checkOutput("t1.fail", 32'(fail), 0);
        checkOutput("t1.match_cnt", 32'(match_cnt), 1);
        checkOutput("t1.cycle_cnt", 32'(cycle_cnt), 2);
        doStart();
        checkOutput("t1.start_ignored", 32'(pass), 1);
        doClear();
        checkAllZero("t1.clear");

        // Wrong data in strict mode -> mismatch FAIL, then clear from FAIL
        doLoad(100, 7);
        doStart();
        applyStimulus(100, 8);
        checkOutput("t2.fail", 32'(fail), 1);
        checkOutput("t2.done", 32'(done), 1);
        checkOutput("t2.fail_code", 32'(fail_code), 1);
        checkOutput("t2.fail_adr", fail_adr, 100);
        checkOutput("t2.fail_data", fail_data, 8);
        checkOutput("t2.match_cnt", 32'(match_cnt), 0);
        doClear();
        checkAllZero("t2.clear");

        // Lenient mode skips the stray write
        strict = 1'b0;
        doLoad(32'h10, 1);
        doLoad(32'h14, 2);
        doStart();
        applyStimulus(32'h10, 1);
        checkOutput("t3.match1", 32'(match_cnt), 1);
        applyStimulus(32'h20, 9);
        checkOutput("t3.stray_busy", 32'(busy), 1);
        checkOutput("t3.stray_match", 32'(match_cnt), 1);
        applyStimulus(32'h14, 2);
        checkOutput("t3.pass", 32'(pass), 1);
        checkOutput("t3.match_cnt", 32'(match_cnt), 2);
        doClear();

        // Same sequence in strict mode fails on the stray write
        strict = 1'b1;
        doLoad(32'h10, 1);
        doLoad(32'h14, 2);
        doStart();
        applyStimulus(32'h10, 1);
        applyStimulus(32'h20, 9);
        checkOutput("t3s.fail", 32'(fail), 1);
        checkOutput("t3s.fail_code", 32'(fail_code), 1);
        checkOutput("t3s.fail_adr", fail_adr, 32'h20);
        checkOutput("t3s.fail_data", fail_data, 9);
        checkOutput("t3s.match_cnt", 32'(match_cnt), 1);
        doClear();

        // Timeout exactly TIMEOUT edges after start
        doLoad(100, 7);
        doStart();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        checkOutput("t4.pre_busy", 32'(busy), 1);
        checkOutput("t4.pre_fail", 32'(fail), 0);
        checkOutput("t4.pre_cycle", 32'(cycle_cnt), TIMEOUT - 1);
        tick();
        checkOutput("t4.fail", 32'(fail), 1);
        checkOutput("t4.fail_code", 32'(fail_code), 2);
        checkOutput("t4.cycle_cnt", 32'(cycle_cnt), TIMEOUT);
        doClear();

        // Matching write on the timeout edge wins
        doLoad(100, 7);
        doStart();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        applyStimulus(100, 7);
        checkOutput("t4m.pass", 32'(pass), 1);
        checkOutput("t4m.fail", 32'(fail), 0);
        checkOutput("t4m.fail_code", 32'(fail_code), 0);
        doClear();

        // Table overflow, then empty-table run
        for (int i = 0; i < DEPTH; i++) doLoad(32'(i * 4), 32'(i));
        checkOutput("t5.loaded4", 32'(loaded_cnt), 4);
        checkOutput("t5.not_full", 32'(load_full), 0);
        doLoad(32'h40, 5);
        checkOutput("t5.loaded_cnt", 32'(loaded_cnt), 4);
        checkOutput("t5.load_full", 32'(load_full), 1);
        doClear();
        checkOutput("t5.clr_full", 32'(load_full), 0);
        checkOutput("t5.clr_loaded", 32'(loaded_cnt), 0);
        doStart();
        checkOutput("t5.busy", 32'(busy), 1);
        tick();
        checkOutput("t5.empty_pass", 32'(pass), 1);
        doClear();

        // Asynchronous reset mid-RUN
        doLoad(32'h10, 1);
        doLoad(32'h14, 2);
        doStart();
        applyStimulus(32'h10, 1);
        checkOutput("t6.pre_match", 32'(match_cnt), 1);
        checkOutput("t6.pre_busy", 32'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("t6.reset");
        @(negedge clk);
        reset = 1'b1;
        tick();
        checkOutput("t6.idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable, parametrised self-check monitor for the processor's data-memory write port, generalising the single-address pass/fail check used in simulation. It snoops `mem_write`/`data_adr`/`write_data` from `top`, compares writes against a loadable ordered table of expected (address, data) pairs, skips a programmable ignore address, and reports pass, fail or timeout with the offending write captured. It sits beside `top` in both the bench and the FPGA build, so the same program check runs on silicon.

## Interface

- `WIDTH`, 32, address and data width
- `DEPTH`, 4, number of expected-write entries
- `TIMEOUT`, 1024, cycles allowed in RUN before a timeout fail
- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `mem_write`  in  1  processor memory write strobe
- `data_adr`  in  WIDTH  processor write address
- `write_data`  in  WIDTH  processor write data
- `load_en`  in  1  append (`load_adr`, `load_data`) to table; honoured in IDLE only
- `load_adr`  in  WIDTH  expected address
- `load_data`  in  WIDTH  expected data
- `ignore_en`  in  1  enable ignore address
- `ignore_adr`  in  WIDTH  writes to this address never match or fail
- `strict`  in  1  1: any non-ignored, non-matching write fails; 0: such writes are skipped
- `start`  in  1  IDLE -> RUN pulse
- `clear`  in  1  synchronous return to IDLE, flush table and status
- `busy`  out  1  high in RUN
- `done`  out  1  high in PASS or FAIL
- `pass`  out  1  high in PASS
- `fail`  out  1  high in FAIL
- `fail_code`  out  2  0 none, 1 mismatch, 2 timeout
- `loaded_cnt`  out  $clog2(DEPTH+1)  entries loaded
- `load_full`  out  1  sticky: a load was dropped because the table was full
- `match_cnt`  out  $clog2(DEPTH+1)  entries matched so far
- `cycle_cnt`  out  $clog2(TIMEOUT+1)  cycles spent in RUN, saturating
- `fail_adr`, `fail_data`  out  WIDTH  write that caused a mismatch fail

## Operation

- States: IDLE, RUN, PASS, FAIL. Reset enters IDLE; every output and counter is 0, table empty.
- IDLE: `load_en` writes entry `loaded_cnt` and increments it. If `loaded_cnt == DEPTH`, the load is dropped and `load_full` is set. `start` -> RUN; `cycle_cnt` and `match_cnt` are zeroed.
- RUN, per rising edge with `mem_write = 1`, in priority order:
  - ignore hit (`ignore_en` and `data_adr == ignore_adr`): no effect
  - address and data equal entry `match_cnt`: `match_cnt` increments; if the new value equals `loaded_cnt`, go to PASS
  - otherwise, if `strict`: go to FAIL, `fail_code = 1`, capture `fail_adr`/`fail_data`
  - otherwise (lenient): no effect
- RUN with `loaded_cnt == 0`: go to PASS on the first RUN edge.
- Timeout: when `cycle_cnt` reaches TIMEOUT with no PASS or mismatch, go to FAIL with `fail_code = 2`. A match that completes the table on that same edge wins, giving PASS.
- PASS and FAIL hold until `clear` or reset; `start` is ignored there. `start` and `load_en` are ignored in RUN.
- `clear` in any state: go to IDLE; `loaded_cnt`, `match_cnt`, `cycle_cnt`, `load_full`, `fail_code`, `fail_adr`/`fail_data` are all zeroed. `clear` has priority over `start` and `load_en`.
- Equality is full-width bitwise compare. Counters never wrap: `cycle_cnt` saturates at TIMEOUT.

## Timing

- All outputs are registered; no combinational input-to-output path.
- Write observed at edge N: `match_cnt`, `pass`/`fail` and the captured fields are valid after edge N (one-cycle latency). `done` rises with them.
- `start` sampled at edge N: `busy` is high from edge N; the first write checked is at edge N+1.
- `cycle_cnt` increments on every RUN edge after entry; timeout fail appears after edge N+TIMEOUT.
- `reset` low clears state immediately (asynchronous); release is synchronous to `clk`.

## Test plan

- Load (100,7); ignore_adr=96, ignore_en=1, strict=1; start; writes (96,3) then (100,7) -> `pass = 1`, `done = 1`, `match_cnt = 1` one cycle after the second write; `fail` stays 0.
- Same setup; write (100,8) -> `fail = 1`, `fail_code = 1`, `fail_adr = 100`, `fail_data = 8`, `match_cnt = 0`.
- strict=0; load (0x10,1) and (0x14,2); writes (0x10,1), (0x20,9), (0x14,2) -> `pass = 1`, `match_cnt = 2`; with strict=1 the (0x20,9) write instead gives `fail_code = 1`.
- TIMEOUT=16; load one entry; start and issue no writes -> `fail = 1`, `fail_code = 2` exactly 16 edges after `start`; a matching write on edge 16 gives `pass` instead.
- DEPTH=4; load 5 entries -> `loaded_cnt = 4`, `load_full = 1`. Then `clear` and `start` with an empty table -> `pass = 1` after the first RUN edge.
- Drive `reset` low mid-RUN -> all outputs 0 with no clock edge. `clear` in FAIL -> IDLE with all status fields 0.
